// File: rtl/mni_out_arb_if.sv
// Flit handshake bundle between the packet sources, the output arbiter and the
// MNI network output port.
//   i_req_valid/i_req_data/i_req_last : per-requester flit stream (requester k
//                                       uses i_req_data[k*DW +: DW])
//   o_req_stall                       : per-requester back-pressure
//   o_out_valid/o_out_data/o_out_last : arbitrated flit stream to the network
//   i_out_stall                       : network back-pressure
// Modports: master = sources + network side, slave = arbiter.
interface mni_out_arb_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DW    = 16
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ*DW-1:0] i_req_data;
  logic [N_REQ-1:0]    i_req_last;
  logic [N_REQ-1:0]    o_req_stall;
  logic                o_out_valid;
  logic [DW-1:0]       o_out_data;
  logic                o_out_last;
  logic                i_out_stall;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_out_stall,
    input  o_req_stall, o_out_valid, o_out_data, o_out_last
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_out_stall,
    output o_req_stall, o_out_valid, o_out_data, o_out_last
  );
endinterface

// File: rtl/mni_out_arb.sv
// Round-robin packet arbiter for the MNI network output port. Shares one flit
// stream among N_REQ sources (index 0 = L2C writeback path), holding the grant
// for a whole packet. Packets longer than MAX_FLITS are cut and flagged.
// Ports:
//   clk_ni        NI clock, rising edge
//   rst_ni        asynchronous active-low reset
//   bus           flit handshake bundle (slave side)
//   o_grant       one-hot current owner, zero when idle
//   o_err_overlen sticky overlong-packet flag
//   i_err_clr     clears o_err_overlen (a simultaneous cut wins)
module mni_out_arb #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_FLITS = 36
) (
  input  logic             clk_ni,
  input  logic             rst_ni,
  mni_out_arb_if.slave     bus,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_err_overlen,
  input  logic             i_err_clr
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_FLITS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    cnt;
  logic             err;

  logic [IW-1:0]    pick;
  logic             any_req;
  logic             busy;
  logic             own_valid;
  logic             own_last;
  logic [DW-1:0]    own_data;
  logic             cut;
  logic             out_valid;
  logic             out_last;
  logic             accept;
  logic [N_REQ-1:0] stall;

  // First valid requester at or after rr_ptr, scanning cyclically.
  always_comb begin
    int unsigned k;
    k       = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(rr_ptr) + i) % N_REQ;
      if (!any_req && bus.i_req_valid[k]) begin
        any_req = 1'b1;
        pick    = IW'(k);
      end
    end
  end

  // Data path is combinational from the owner to the network and back.
  always_comb begin
    busy      = (state == BUSY);
    own_valid = bus.i_req_valid[gidx];
    own_last  = bus.i_req_last[gidx];
    own_data  = bus.i_req_data[gidx*DW +: DW];
    cut       = (cnt == CW'(MAX_FLITS - 1));
    out_valid = busy & own_valid;
    out_last  = out_valid & (own_last | cut);
    accept    = out_valid & ~bus.i_out_stall;
    stall     = '1;
    if (busy) stall[gidx] = bus.i_out_stall;
  end

  assign bus.o_out_valid = out_valid;
  assign bus.o_out_last  = out_last;
  assign bus.o_out_data  = busy ? own_data : '0;
  assign bus.o_req_stall = stall;
  assign o_grant         = grant;
  assign o_err_overlen   = err;

  always_ff @(posedge clk_ni or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      // A cut accept sets the flag even if a clear arrives in the same cycle.
      if (accept && cut && !own_last) err <= 1'b1;
      else if (i_err_clr)             err <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            grant <= N_REQ'(1) << pick;
            gidx  <= pick;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (accept) begin
            if (out_last) begin
              state  <= IDLE;
              grant  <= '0;
              cnt    <= '0;
              rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mni_out_arb.sv
module tb_mni_out_arb;
  localparam int unsigned N    = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned MAXF = 36;

  logic         clk_ni = 1'b0;
  logic         rst_ni;
  logic [N-1:0] grant;
  logic         err;
  logic         err_clr;

  mni_out_arb_if #(.N_REQ(N), .DW(DW)) bus();

  mni_out_arb #(.N_REQ(N), .DW(DW), .MAX_FLITS(MAXF)) dut (
    .clk_ni       (clk_ni),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .o_grant      (grant),
    .o_err_overlen(err),
    .i_err_clr    (err_clr)
  );

  always #5 clk_ni = ~clk_ni;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Source flit queues: {last, data}
  logic [16:0] srcq [N][$];

  // Reference model: current owner (-1 = none), rotation pointer, flit count, flag
  int     m_owner;
  int     m_ptr;
  int     m_cnt;
  bit     m_err;
  bit     tgl;
  int     gseq[$];
  logic [N-1:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pkt(input int k, input int len);
    for (int i = 0; i < len; i++)
      srcq[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 16'($urandom)});
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_cnt      = 0;
    m_err      = 1'b0;
    prev_grant = '0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle(input int unsigned vpct, input int unsigned smode, input bit clr);
    logic [N-1:0]  v, l, e_stall, e_grant;
    logic [DW-1:0] d [N];
    logic [DW-1:0] e_data;
    logic          ost, e_valid, e_last, acc;
    int            g, gi;
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        v[k] = ($urandom_range(99) < vpct);
        d[k] = srcq[k][0][15:0];
        l[k] = srcq[k][0][16];
      end else begin
        v[k] = 1'b0;
        d[k] = '0;
        l[k] = 1'b0;
      end
      bus.i_req_data[k*DW +: DW] = d[k];
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    case (smode)
      0:       ost = 1'b0;
      1:       begin ost = tgl; tgl = ~tgl; end
      default: ost = 1'($urandom_range(1));
    endcase
    bus.i_out_stall = ost;
    err_clr         = clr;
    #1;
    g = m_owner;
    if (g < 0) begin
      e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_stall = '1; e_grant = '0;
    end else begin
      e_valid    = v[g];
      e_last     = v[g] & (l[g] | (m_cnt == MAXF - 1));
      e_data     = d[g];
      e_stall    = '1;
      e_stall[g] = ost;
      e_grant    = '0;
      e_grant[g] = 1'b1;
    end
    check("grant", 32'(grant), 32'(e_grant));
    check("out_valid", 32'(bus.o_out_valid), 32'(e_valid));
    check("out_last", 32'(bus.o_out_last), 32'(e_last));
    check("out_data", 32'(bus.o_out_data), 32'(e_data));
    check("req_stall", 32'(bus.o_req_stall), 32'(e_stall));
    check("err_overlen", 32'(err), 32'(m_err));
    if (prev_grant == '0 && grant != '0) begin
      gi = -1;
      for (int k = 0; k < N; k++) if (grant[k]) gi = k;
      gseq.push_back(gi);
    end
    prev_grant = grant;
    if (g < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && v[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_cnt   = 0;
        end
      end
      if (clr) m_err = 1'b0;
    end else begin
      acc = v[g] & ~ost;
      if (acc && e_last && !l[g]) m_err = 1'b1;
      else if (clr)               m_err = 1'b0;
      if (acc) begin
        void'(srcq[g].pop_front());
        if (e_last) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk_ni);
    #1;
  endtask

  task automatic drain(input int unsigned vpct, input int unsigned smode);
    int budget;
    budget = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() > 0 || m_owner >= 0)
           && budget < 3000) begin
      cycle(vpct, smode, 1'b0);
      budget++;
    end
    if (budget >= 3000) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst_ni          = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    err_clr         = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(bus.o_out_valid), 32'd0);
    check("rst_last", 32'(bus.o_out_last), 32'd0);
    check("rst_data", 32'(bus.o_out_data), 32'd0);
    check("rst_stall", 32'(bus.o_req_stall), 32'(3'b111));
    check("rst_err", 32'(err), 32'd0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    model_reset();
    @(posedge clk_ni);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int exp_q[$]);
    check({tag, "_len"}, 32'(gseq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gseq.size(); i++)
      check(tag, 32'(gseq[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int exp_q[$];
    rst_ni          = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_out_stall = 1'b0;
    err_clr         = 1'b0;
    tgl             = 1'b0;
    model_reset();
    @(posedge clk_ni);
    #1;
    do_reset();

    // Lone requester, maximum legal packet, no back-pressure
    gseq.delete();
    push_pkt(0, 36);
    drain(100, 0);
    exp_q = '{0};
    check_seq("seq_single", exp_q);
    check("no_err_36", 32'(err), 32'd0);

    // All three requesters, three 4-flit packets each
    do_reset();
    gseq.delete();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < N; k++) push_pkt(k, 4);
    drain(100, 0);
    exp_q = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    check_seq("seq_rr", exp_q);

    // Toggling network stall during a req1 packet
    push_pkt(1, 10);
    drain(100, 1);

    // Overlong packet from req2 is cut and re-arbitrated
    gseq.delete();
    push_pkt(2, 40);
    drain(100, 0);
    check("err_sticky", 32'(err), 32'd1);
    exp_q = '{2, 2};
    check_seq("seq_cut", exp_q);
    cycle(100, 0, 1'b1);
    check("err_cleared", 32'(err), 32'd0);

    // Single-flit packets from req0 against a waiting req1
    do_reset();
    gseq.delete();
    for (int i = 0; i < 4; i++) push_pkt(0, 1);
    for (int i = 0; i < 3; i++) push_pkt(1, 1);
    drain(100, 0);
    exp_q = '{0, 1, 0, 1, 0, 1, 0};
    check_seq("seq_alt", exp_q);

    // Random traffic with gaps, stalls and occasional clears
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) begin
        int k;
        k = $urandom_range(N - 1);
        if (srcq[k].size() < 50) push_pkt(k, $urandom_range(1, 40));
      end
      cycle($urandom_range(50, 100), 2, ($urandom_range(19) == 0));
    end
    drain(80, 2);

    // Reset in the middle of a 20-flit packet
    do_reset();
    push_pkt(2, 20);
    for (int c = 0; c < 100 && !(m_owner == 2 && m_cnt == 9); c++) cycle(100, 0, 1'b0);
    check("mid_pkt_reached", 32'(m_cnt), 32'd9);
    do_reset();
    gseq.delete();
    push_pkt(1, 3);
    push_pkt(2, 3);
    drain(100, 0);
    exp_q = '{1, 2};
    check_seq("seq_post_rst", exp_q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
